// File: rtl/packet_byte_unloader.sv
// Unloads a PACKET_WIDTH-byte packet one byte at a time over a valid/ready
// handshake, with a one-deep pending slot for a packet arriving mid-unload.
`timescale 1ns/1ps
module packet_byte_unloader #(
  parameter int PACKET_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PACKET_WIDTH-1:0][7:0] sys_packet,
  input  logic                         packet_valid,
  output logic [7:0]                   word,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         busy,
  output logic                         overflow
);

  localparam int IW = $clog2(PACKET_WIDTH) + 1;
  localparam int SW = $clog2(PACKET_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(PACKET_WIDTH - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                       r_state;
  logic [PACKET_WIDTH-1:0][7:0] r_shadow;
  logic [PACKET_WIDTH-1:0][7:0] r_pending;
  logic                         r_pending_valid;
  logic [IW-1:0]                r_index;
  logic                         r_overflow;

  logic          w_last;
  logic          w_xfer;
  logic [SW-1:0] w_sel;

  // An out-of-range index is treated as the last byte, both for the
  // output mux and for the end-of-packet decision.
  assign w_last = (r_index >= LAST_IDX);
  assign w_sel  = w_last ? SW'(PACKET_WIDTH - 1) : r_index[SW-1:0];
  assign w_xfer = (r_state == EMIT) && word_ready;

  assign word       = r_shadow[w_sel];
  assign word_valid = (r_state == EMIT);
  assign busy       = (r_state == EMIT) || r_pending_valid;
  assign overflow   = r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_shadow        <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_index         <= '0;
      r_overflow      <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      case (r_state)
        IDLE: begin
          if (packet_valid) begin
            r_shadow <= sys_packet;
            r_index  <= '0;
            r_state  <= EMIT;
          end
        end
        EMIT: begin
          if (w_xfer && w_last) begin
            r_index <= '0;
            if (r_pending_valid) begin
              r_shadow <= r_pending;
              if (packet_valid) r_pending <= sys_packet;
              else              r_pending_valid <= 1'b0;
            end else if (packet_valid) begin
              r_shadow <= sys_packet;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            if (w_xfer) r_index <= r_index + IW'(1);
            if (packet_valid) begin
              if (!r_pending_valid) begin
                r_pending       <= sys_packet;
                r_pending_valid <= 1'b1;
              end else begin
                r_overflow <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_byte_unloader.sv
// Scoreboard bench for packet_byte_unloader: directed scenarios then random
// traffic, checked against a packet-occupancy reference model.
`timescale 1ns/1ps
module tb_packet_byte_unloader;

  localparam int PW = 4;

  typedef logic [PW-1:0][7:0] pkt_t;
  typedef struct packed {
    logic ovf;
    logic active;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  pkt_t       sys_packet = '0;
  logic       packet_valid = 1'b0;
  logic [7:0] word;
  logic       word_valid;
  logic       word_ready = 1'b0;
  logic       busy;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_bytes[$];
  exp_t       exp_state[$];
  int         held = 0;   // packets accepted and not fully sent (0..2)
  int         rem  = PW;  // bytes left of the packet at the head

  packet_byte_unloader #(.PACKET_WIDTH(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sys_packet   (sys_packet),
    .packet_valid (packet_valid),
    .word         (word),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus; the model decides what the coming edge does.
  task automatic cycle(input logic pv, input pkt_t pkt, input logic rdy);
    logic xfer, completes, ovf;
    @(posedge clk);
    #1;
    packet_valid = pv;
    sys_packet   = pv ? pkt : pkt_t'('0);
    word_ready   = rdy;
    xfer      = (held > 0) && rdy;
    completes = xfer && (rem == 1);
    ovf       = 1'b0;
    if (xfer) begin
      rem--;
      if (rem == 0) begin
        held--;
        rem = PW;
      end
    end
    if (pv) begin
      if (held < 2) begin
        for (int i = 0; i < PW; i++) exp_bytes.push_back(pkt[i]);
        held++;
      end else begin
        ovf = 1'b1;
      end
    end
    exp_state.push_back('{ovf: ovf, active: (held > 0)});
    if (completes && held == 2) $display("note: simultaneous arrival with full pending at %0t", $time);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
  endtask

  function automatic pkt_t mk(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    pkt_t p;
    p[0] = b0; p[1] = b1; p[2] = b2; p[3] = b3;
    return p;
  endfunction

  // Monitor: compares the DUT against the scoreboard mid-cycle.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_word  = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_state.size() >= 2) begin
        e = exp_state.pop_front();
        check("overflow", {7'd0, overflow}, {7'd0, e.ovf});
        check("word_valid", {7'd0, word_valid}, {7'd0, e.active});
        check("busy", {7'd0, busy}, {7'd0, e.active});
      end
      if (prev_stall && reset) begin
        check("hold_valid", {7'd0, word_valid}, 8'd1);
        check("hold_word", word, prev_word);
      end
      if (word_valid && word_ready) begin
        if (exp_bytes.size() == 0) begin
          check("unexpected_byte", word, 8'hxx);
        end else begin
          check("byte", word, exp_bytes.pop_front());
        end
      end
      prev_stall = reset && word_valid && !word_ready;
      prev_word  = word;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t pa, pb, pc, pr;
    logic [7:0] rdy_pat[7];
    pa = mk(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    pb = mk(8'h11, 8'h22, 8'h33, 8'h44);
    pc = mk(8'h55, 8'h66, 8'h77, 8'h88);
    rdy_pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_word_valid", {7'd0, word_valid}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_overflow", {7'd0, overflow}, 8'd0);
    check("rst_word", word, 8'h00);
    reset = 1'b1;

    // single packet, full throughput
    cycle(1'b1, pa, 1'b1);
    idle(6);

    // backpressure
    cycle(1'b1, pa, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, rdy_pat[i][0]);
    idle(4);

    // pending packet arriving during byte 1
    cycle(1'b1, pa, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, pb, 1'b1);
    idle(9);

    // overflow: three packets while byte 0 stalls
    cycle(1'b1, pa, 1'b0);
    cycle(1'b1, pb, 1'b0);
    cycle(1'b1, pc, 1'b0);
    cycle(1'b0, '0, 1'b0);
    idle(10);

    // simultaneous arrival on last transfer, pending empty
    cycle(1'b1, pa, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, pb, 1'b1);
    idle(6);

    // simultaneous arrival on last transfer, pending full
    cycle(1'b1, pa, 1'b1);
    cycle(1'b1, pb, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, pc, 1'b1);
    idle(14);

    // reset mid-operation during byte 2 with a packet pending
    cycle(1'b1, pa, 1'b1);
    cycle(1'b1, pb, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_word_valid", {7'd0, word_valid}, 8'd0);
    check("midrst_busy", {7'd0, busy}, 8'd0);
    exp_bytes.delete();
    exp_state.delete();
    exp_state.push_back('{ovf: 1'b0, active: 1'b0});
    exp_state.push_back('{ovf: 1'b0, active: 1'b0});
    held = 0;
    rem  = PW;
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    reset = 1'b1;
    cycle(1'b1, pc, 1'b1);
    idle(6);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < PW; i++) pr[i] = 8'($urandom);
      cycle(($urandom_range(0, 3) == 0), pr, ($urandom_range(0, 9) < 7));
    end
    idle(20);

    check("bytes_left", 8'(exp_bytes.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/packet_byte_unloader.md
# packet_byte_unloader

Transmit-side counterpart of the receive-path byte packer: accepts a complete PACKET_WIDTH-byte system packet (e.g. from the demodulator/deframer) and unloads it one byte at a time into the UART transmitter over a valid/ready handshake. It sits between the packet-level datapath and the byte-serial UART output. A one-deep pending slot absorbs one packet that arrives while another is unloading. Packets arriving beyond that are dropped and flagged.

## Interface
- PACKET_WIDTH, default 4: bytes per packet (same value as the core parameter set); must be ≥ 2.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- sys_packet  in  [PACKET_WIDTH-1:0][7:0]  packet; byte index 0 is sent first.
- packet_valid  in  1  single-cycle pulse; sys_packet valid in that cycle only.
- word  out  8  current byte offered to the UART transmitter.
- word_valid  out  1  word is valid; held until accepted.
- word_ready  in  1  UART transmitter can take word this cycle.
- busy  out  1  high while unloading or while a packet is pending.
- overflow  out  1  one-cycle pulse: an incoming packet was dropped.

## Operation
- Registers: active packet shadow, byte index [$clog2(PACKET_WIDTH):0], pending packet, pending_valid, state.
- States: IDLE, EMIT.
- IDLE: word_valid=0. On packet_valid: copy sys_packet to shadow, index←0, go to EMIT.
- EMIT: word_valid=1, word=shadow[index]. Transfer occurs on an edge where word_valid && word_ready.
  - Transfer, index < PACKET_WIDTH-1: index←index+1.
  - Transfer, index = PACKET_WIDTH-1 (last byte), priority order:
    - pending_valid=1: shadow←pending, pending_valid←0, index←0, stay in EMIT. If packet_valid is also high, sys_packet goes into pending and pending_valid stays 1. No overflow.
    - else packet_valid=1: shadow←sys_packet, index←0, stay in EMIT.
    - else: go to IDLE.
  - packet_valid in EMIT when no last-byte transfer occurs:
    - pending_valid=0: pending←sys_packet, pending_valid←1.
    - pending_valid=1: drop the packet, pulse overflow for one cycle, leave pending unchanged.
- word and word_valid must not change while word_valid=1 && word_ready=0. No byte is skipped or repeated.
- word_ready while in IDLE is ignored.
- busy = (state==EMIT) || pending_valid.
- Index arithmetic never wraps past PACKET_WIDTH-1. An index ≥ PACKET_WIDTH is unreachable; if it occurs, treat it as last byte.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, index=0, shadow=0, pending=0, pending_valid=0, word=0, word_valid=0, busy=0, overflow=0. Reset mid-packet discards the remaining bytes and the pending packet. The first packet_valid after release is handled normally.
- Latency: packet_valid at edge N (IDLE) → word_valid=1, word=byte0 after edge N.
- Throughput: with word_ready held 1, one byte per cycle. PACKET_WIDTH transfers occur on edges N+1 … N+PACKET_WIDTH.
- Back-to-back: if a pending or simultaneous packet exists at the last transfer, word_valid stays 1 with no bubble and the next byte0 follows directly.
- overflow is registered: it is high in the cycle after the dropped packet_valid edge.
- busy falls in the cycle after the final transfer when nothing is pending.

## Test plan
- Single packet, PACKET_WIDTH=4, sys_packet bytes {0:0xA1,1:0xB2,2:0xC3,3:0xD4}, word_ready=1 → words A1,B2,C3,D4 on 4 consecutive cycles. Then word_valid=0 and busy=0. overflow never asserts.
- Backpressure: same packet, word_ready toggling 1,0,0,1,0,1,1 → each byte is held stable while ready=0. Sequence is exactly A1,B2,C3,D4 with no duplicates.
- Pending: second packet {0x11,0x22,0x33,0x44} pulsed during byte 1 of the first → 8 bytes out with no gap between D4 and 11. busy stays high throughout.
- Overflow: three packets pulsed during the first packet's byte 0 with word_ready=0 → 2nd is queued, 3rd is dropped with a one-cycle overflow pulse. Output is 8 bytes: packets 1 and 2 only.
- Simultaneous: packet_valid coincident with the last-byte transfer, both with pending empty and with pending full → no overflow, order preserved, no bubble.
- Reset mid-operation: assert reset low asynchronously during byte 2 with a packet pending → word_valid and busy drop immediately. After release, a new packet unloads from byte 0.
